byte_shift_scheduler: RTL and testbench

Round-robin scheduler that shares one byte-serial shift channel among `NUM_REQ` byte sources. It drives the `shift`/data inputs of a downstream 32-bit shift-accumulate producer. A word is always assembled from a single requester: the block locks that requester for `BYTES_PER_WORD` accepted bytes, then presents the completed word with a valid/ready handshake before re-arbitrating.

---
 rtl/byte_shift_scheduler_pkg.sv | 17 +
 rtl/byte_shift_scheduler_if.sv | 29 ++
 rtl/byte_shift_scheduler_rr_arbiter.sv | 33 +++
 rtl/byte_shift_scheduler.sv | 100 ++++++++++
 tb/tb_byte_shift_scheduler.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_shift_scheduler_pkg.sv
// Shared types and helpers for the byte shift scheduler.
package shift_sched_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PRESENT
    } sched_state_t;

    // Next round-robin position with an explicit wrap, so any requester count works.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/byte_shift_scheduler_if.sv
// Requester, producer and word handshake signals of the byte shift scheduler.
interface byte_shift_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int OWNER_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                        req;
    logic [NUM_REQ*shift_sched_pkg::BYTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]                        grant;
    logic                                      shift;
    logic [shift_sched_pkg::BYTE_W-1:0]        shift_data;
    logic                                      word_valid;
    logic                                      word_ready;
    logic [OWNER_W-1:0]                        word_owner;
    logic                                      busy;

    // Scheduler side.
    modport master (
        input  req, req_data, word_ready,
        output grant, shift, shift_data, word_valid, word_owner, busy
    );

    // Requesters, producer and word consumer side.
    modport slave (
        output req, req_data, word_ready,
        input  grant, shift, shift_data, word_valid, word_owner, busy
    );

endinterface

// File: rtl/byte_shift_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set request at or after the pointer, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic                 o_found,
    output logic [$clog2(N)-1:0] o_idx
);
    localparam int IDX_W = $clog2(N);

    // One extra bit holds ptr+k before the wrap back into 0..N-1.
    logic [IDX_W:0] w_sum;

    // Scan N candidates starting at the pointer; the first hit wins.
    always_comb begin
        // NOTE: every output and temporary gets a default first so no path leaves it unassigned (no latch).
        o_found = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            if (!o_found && i_req[w_sum[IDX_W-1:0]]) begin
                o_found = 1'b1;
                o_idx   = w_sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/byte_shift_scheduler.sv
// Round-robin scheduler sharing one byte-serial shift channel among NUM_REQ sources.
// An owner is locked for a whole word, which is then presented with valid/ready.
module byte_shift_scheduler
    import shift_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                    clock,
    input  logic                    clear,
    byte_shift_scheduler_if.master  bus
);
    localparam int OWNER_W = $clog2(NUM_REQ);
    localparam int COUNT_W = $clog2(BYTES_PER_WORD + 1);

    sched_state_t       r_state;
    sched_state_t       w_state_nxt;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_count_nxt;
    logic [OWNER_W-1:0] r_owner;
    logic [OWNER_W-1:0] w_owner_nxt;
    logic [OWNER_W-1:0] r_rr_ptr;
    logic [OWNER_W-1:0] w_rr_ptr_nxt;
    logic               w_found;
    logic [OWNER_W-1:0] w_pick;
    logic               w_owner_req;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_req   (bus.req),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign bus.word_owner = r_owner;
    assign bus.busy       = (r_state != IDLE);

    // Next-state logic plus the grant/shift/valid outputs; outputs idle outside their state.
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_req    = bus.req[r_owner];
        bus.grant      = '0;
        bus.shift      = 1'b0;
        bus.shift_data = '0;
        bus.word_valid = 1'b0;

        case (r_state)
            IDLE: begin
                // Selection costs one cycle; no byte moves while picking an owner.
                if (w_found) begin
                    w_owner_nxt = w_pick;
                    w_count_nxt = '0;
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                // Only the locked owner is ever granted; if it drops req we simply stall.
                bus.grant[r_owner] = w_owner_req;
                bus.shift          = w_owner_req;
                bus.shift_data     = bus.req_data[r_owner*BYTE_W +: BYTE_W];
                if (w_owner_req) begin
                    w_count_nxt = r_count + COUNT_W'(1);
                    if (r_count == COUNT_W'(BYTES_PER_WORD - 1)) begin
                        w_state_nxt = PRESENT;
                    end
                end
            end
            PRESENT: begin
                bus.word_valid = 1'b1;
                if (bus.word_ready) begin
                    w_rr_ptr_nxt = OWNER_W'(rr_next(int'(r_owner), NUM_REQ));
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, byte count, owner and round-robin pointer; clear wins over any transition.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (clear) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_byte_shift_scheduler.sv
// Self-checking bench: requester byte sources, a model of the 32-bit shift-accumulate
// producer, and a scoreboard of expected (owner, word) pairs.
module tb_byte_shift_scheduler;
    import shift_sched_pkg::*;

    logic clock  = 1'b0;
    logic clear  = 1'b1;
    logic clear3 = 1'b1;

    always #5 clock = ~clock;

    byte_shift_scheduler_if #(.NUM_REQ(4)) bus ();
    byte_shift_scheduler #(.NUM_REQ(4), .BYTES_PER_WORD(4)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    byte_shift_scheduler_if #(.NUM_REQ(3)) bus3 ();
    byte_shift_scheduler #(.NUM_REQ(3), .BYTES_PER_WORD(4)) dut3 (
        .clock (clock),
        .clear (clear3),
        .bus   (bus3)
    );

    typedef struct {
        logic [1:0]  owner;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    int          rise_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_words  = 0;
    int          cyc      = 0;
    int          shifts_in_word = 0;
    int          src_idx[4];
    int          exp_k[4];
    logic [3:0]  req_en   = 4'hF;
    logic [31:0] prod_word = '0;
    logic        prev_valid = 1'b0;
    logic [3:0]  last_grant;
    logic        last_shift;
    logic        last_valid;
    logic [1:0]  last_owner;

    // Byte number k offered by requester i (requester 2 starts A1,B2,C3,D4).
    function automatic logic [7:0] src_byte(input int i, input int k);
        return 8'(8'hA1 + 8'h11 * k + 8'h40 * (i ^ 2));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input int owner);
        exp_t e;
        e.owner = 2'(owner);
        e.word  = {src_byte(owner, exp_k[owner]),     src_byte(owner, exp_k[owner] + 1),
                   src_byte(owner, exp_k[owner] + 2), src_byte(owner, exp_k[owner] + 3)};
        exp_k[owner] += 4;
        exp_q.push_back(e);
    endtask

    // One clock: drive requesters, observe outputs before the edge, model the producer, advance.
    task automatic cycle();
        exp_t e;
        for (int i = 0; i < 4; i++) bus.req_data[8*i +: 8] = src_byte(i, src_idx[i]);
        bus.req = req_en;
        #1;
        last_grant = bus.grant;
        last_shift = bus.shift;
        last_valid = bus.word_valid;
        last_owner = bus.word_owner;
        if (bus.word_valid && !prev_valid) rise_q.push_back(cyc);
        prev_valid = bus.word_valid;
        if (clear) begin
            prod_word = '0;
        end else begin
            if (bus.shift) begin
                check("grant_onehot", 32'(bus.grant), 32'(1) << bus.word_owner);
                prod_word = {prod_word[23:0], bus.shift_data};
                shifts_in_word++;
                for (int i = 0; i < 4; i++) if (bus.grant[i]) src_idx[i]++;
            end else begin
                check("grant_without_shift", 32'(bus.grant), 32'(0));
            end
            if (bus.word_valid && bus.word_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(exp_q.size()), 32'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("word_owner", 32'(bus.word_owner), 32'(e.owner));
                    check("word_value", prod_word, e.word);
                end
                check("grants_per_word", 32'(shifts_in_word), 32'(4));
                shifts_in_word = 0;
                n_words++;
            end
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    // Hold clear for n edges, checking that every output sits at its reset value.
    task automatic do_clear(input int n);
        clear = 1'b1;
        for (int k = 0; k < n; k++) begin
            cycle();
            check("clr_grant",      32'(bus.grant),      32'(0));
            check("clr_shift",      32'(bus.shift),      32'(0));
            check("clr_shift_data", 32'(bus.shift_data), 32'(0));
            check("clr_word_valid", 32'(bus.word_valid), 32'(0));
            check("clr_word_owner", 32'(bus.word_owner), 32'(0));
            check("clr_busy",       32'(bus.busy),       32'(0));
        end
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_idx[i] = 0;
            exp_k[i]   = 0;
        end
        prod_word      = '0;
        shifts_in_word = 0;
        n_words        = 0;
        prev_valid     = 1'b0;
        exp_q.delete();
        rise_q.delete();
        cyc = 1;
    endtask

    task automatic run_words(input int n, input int budget);
        int start;
        int k;
        start = n_words;
        k     = 0;
        while (n_words - start < n && k < budget) begin
            cycle();
            k++;
        end
        check("words_done", 32'(n_words - start), 32'(n));
    endtask

    initial begin
        int   wrap_exp[$];
        int   budget;
        bus.word_ready  = 1'b1;
        bus.req         = '0;
        bus.req_data    = '0;
        bus3.req        = 3'b000;
        bus3.req_data   = {8'h33, 8'h22, 8'h11};
        bus3.word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_idx[i] = 0;
            exp_k[i]   = 0;
        end
        @(negedge clock);

        // Reset with every requester asking, then the first word.
        req_en = 4'hF;
        do_clear(2);
        push_exp(0);
        run_words(1, 20);
        check("first_valid_seen", 32'(rise_q.size()), 32'(1));
        if (rise_q.size() > 0) check("first_valid_cycle", 32'(rise_q[0]), 32'(6));

        // Fairness: owners 0,1,2,3,0 back to back, one word every 6 cycles.
        do_clear(1);
        req_en = 4'hF;
        bus.word_ready = 1'b1;
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        run_words(5, 60);
        check("fair_valid_rises", 32'(rise_q.size()), 32'(5));
        for (int j = 1; j < rise_q.size(); j++)
            check("fair_valid_period", 32'(rise_q[j] - rise_q[j-1]), 32'(6));

        // Stall: owner 2 drops req after 2 bytes while requester 1 waits.
        do_clear(1);
        req_en = 4'b0100;
        push_exp(2);
        cycle();
        req_en = 4'b0110;
        cycle();
        cycle();
        req_en = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_no_grant", 32'(last_grant), 32'(0));
        end
        check("stall_count_held", 32'(dut.r_count), 32'(2));
        req_en = 4'b0110;
        run_words(1, 20);
        check("stall_word", prod_word, 32'hA1B2C3D4);

        // Backpressure: word held while ready is low.
        do_clear(1);
        req_en = 4'hF;
        bus.word_ready = 1'b0;
        push_exp(0);
        budget = 0;
        last_valid = 1'b0;
        while (!last_valid && budget < 20) begin
            cycle();
            budget++;
        end
        check("bp_valid_seen", 32'(last_valid), 32'(1));
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("bp_valid_held", 32'(last_valid), 32'(1));
            check("bp_no_shift",   32'(last_shift), 32'(0));
            check("bp_owner",      32'(last_owner), 32'(0));
        end
        bus.word_ready = 1'b1;
        run_words(1, 1);
        check("bp_idle_after", 32'(bus.busy), 32'(0));
        check("bp_valid_drop", 32'(bus.word_valid), 32'(0));

        // Mid-word clear after the third byte: partial word discarded.
        do_clear(1);
        req_en = 4'hF;
        for (int k = 0; k < 4; k++) cycle();
        check("mid_shifts_before_clear", 32'(shifts_in_word), 32'(3));
        check("mid_no_valid", 32'(rise_q.size()), 32'(0));
        do_clear(1);
        push_exp(0);
        run_words(1, 20);

        // Three requesters, only 0 and 2 active: 0 first, then 2,0,2 from pointer 1.
        bus3.req = 3'b101;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        clear3 = 1'b0;
        wrap_exp = '{0, 2, 0, 2};
        budget = 0;
        while (wrap_exp.size() > 0 && budget < 60) begin
            @(negedge clock);
            #1;
            if (bus3.shift)
                check("wrap_shift_data", 32'(bus3.shift_data),
                      32'(bus3.req_data[8*bus3.word_owner +: 8]));
            if (bus3.word_valid && bus3.word_ready)
                check("wrap_owner", 32'(bus3.word_owner), 32'(wrap_exp.pop_front()));
            budget++;
        end
        check("wrap_words_left", 32'(wrap_exp.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
